// File: rtl/lemming_pkg.sv
// Shared types and constants for the Lemming controller: state encoding,
// default splat limit and the state-to-activity decoder.
package lemming_pkg;

  typedef enum logic [2:0] {
    WALK_L,
    WALK_R,
    FALL_L,
    FALL_R,
    DIG_L,
    DIG_R,
    SPLAT
  } state_t;

  localparam int unsigned SPLAT_LIMIT_DEFAULT = 20;

  typedef struct packed {
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
  } act_t;

  // One-hot activity flags; SPLAT (and any unused code) decodes to all-zero.
  function automatic act_t decode_state(state_t s);
    act_t a;
    a = '0;
    case (s)
      WALK_L:         a.walk_left  = 1'b1;
      WALK_R:         a.walk_right = 1'b1;
      FALL_L, FALL_R: a.aaah       = 1'b1;
      DIG_L, DIG_R:   a.digging    = 1'b1;
      default:        a            = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lemming_ctrl_if.sv
// World-sensor inputs and activity outputs of one Lemming controller.
interface lemming_ctrl_if;

  logic bump_left;
  logic bump_right;
  logic ground;
  logic dig;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic digging;

  modport master (
    output bump_left, bump_right, ground, dig,
    input  walk_left, walk_right, aaah, digging
  );

  modport slave (
    input  bump_left, bump_right, ground, dig,
    output walk_left, walk_right, aaah, digging
  );

endinterface

// File: rtl/lemming_fall_cnt.sv
// Saturating fall-duration counter with synchronous clear and a flag that
// is raised once the count has reached LIMIT.
module lemming_fall_cnt #(
  parameter int unsigned LIMIT = 20,
  parameter int unsigned CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt >= LIMIT_C);

  // Holding at LIMIT keeps arbitrarily long falls fatal instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lemming_ctrl.sv
// Moore controller for one Lemming: walk, turn on bumps, fall, dig, splat.
// Outputs are decoded from the registered state only.
module lemming_ctrl
  import lemming_pkg::*;
#(
  parameter int unsigned SPLAT_LIMIT = SPLAT_LIMIT_DEFAULT,
  parameter int unsigned CNT_W       = 5
) (
  input logic           clk,
  input logic           areset,
  lemming_ctrl_if.slave io
);

  state_t state;
  state_t next;
  logic   falling;
  logic   at_limit;
  act_t   act;

  assign falling = (state == FALL_L) || (state == FALL_R);

  lemming_fall_cnt #(
    .LIMIT (SPLAT_LIMIT),
    .CNT_W (CNT_W)
  ) u_fall_cnt (
    .clk      (clk),
    .rst      (areset),
    .clr      (!falling),
    .en       (falling),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= WALK_L;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      WALK_L: begin
        if (!io.ground)        next = FALL_L;
        else if (io.dig)       next = DIG_L;
        else if (io.bump_left) next = WALK_R;
      end
      WALK_R: begin
        if (!io.ground)         next = FALL_R;
        else if (io.dig)        next = DIG_R;
        else if (io.bump_right) next = WALK_L;
      end
      FALL_L: begin
        if (io.ground) next = at_limit ? SPLAT : WALK_L;
      end
      FALL_R: begin
        if (io.ground) next = at_limit ? SPLAT : WALK_R;
      end
      DIG_L: begin
        if (!io.ground) next = FALL_L;
      end
      DIG_R: begin
        if (!io.ground) next = FALL_R;
      end
      SPLAT:   next = SPLAT;
      default: next = WALK_L;
    endcase
  end

  assign act           = decode_state(state);
  assign io.walk_left  = act.walk_left;
  assign io.walk_right = act.walk_right;
  assign io.aaah       = act.aaah;
  assign io.digging    = act.digging;

endmodule

// File: tb/tb_lemming_ctrl.sv
// Scoreboard bench for lemming_ctrl: a behavioural model pushes the expected
// activity flags per cycle; they are popped and compared after each edge.
module tb_lemming_ctrl;

  logic clk = 1'b0;
  logic areset = 1'b1;

  lemming_ctrl_if io ();

  lemming_ctrl #(
    .SPLAT_LIMIT (20),
    .CNT_W       (5)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .io     (io)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] expq[$];

  // Model state: 0 WL, 1 WR, 2 FL, 3 FR, 4 DL, 5 DR, 6 SPLAT
  int ms = 0;
  int fall_len = 0;  // aaah cycles so far in the current fall, including the present one

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (wl,wr,aaah,dig)", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_out(input int s);
    case (s)
      0:       return 4'b1000;
      1:       return 4'b0100;
      2, 3:    return 4'b0010;
      4, 5:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] outs();
    return {io.walk_left, io.walk_right, io.aaah, io.digging};
  endfunction

  task automatic model_step(input bit r, input bit bl, input bit br, input bit g, input bit d);
    if (r) begin
      ms = 0;
      fall_len = 0;
    end else begin
      case (ms)
        0: if (!g) begin ms = 2; fall_len = 1; end
           else if (d) ms = 4;
           else if (bl) ms = 1;
        1: if (!g) begin ms = 3; fall_len = 1; end
           else if (d) ms = 5;
           else if (br) ms = 0;
        2, 3: if (!g) fall_len++;
              else if (fall_len <= 20) ms = (ms == 2) ? 0 : 1;
              else ms = 6;
        4: if (!g) begin ms = 2; fall_len = 1; end
        5: if (!g) begin ms = 3; fall_len = 1; end
        default: ms = 6;
      endcase
    end
  endtask

  task automatic step(input string tag, input bit r, input bit bl, input bit br,
                      input bit g, input bit d);
    @(negedge clk);
    areset = r;
    io.bump_left = bl;
    io.bump_right = br;
    io.ground = g;
    io.dig = d;
    model_step(r, bl, br, g, d);
    expq.push_back(model_out(ms));
    @(posedge clk);
    #1;
    if (expq.size() == 0) check({tag, "_noexp"}, outs(), 4'bxxxx);
    else check(tag, outs(), expq.pop_front());
  endtask

  task automatic rnd_step(input string tag);
    step(tag, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
         1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic do_fall(input string tag, input int n);
    for (int i = 0; i < n; i++)
      step(tag, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
    step({tag, "_land"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  int splat_lens[5] = '{21, 24, 35, 67, 1000};

  initial begin
    io.bump_left = 1'b0;
    io.bump_right = 1'b0;
    io.ground = 1'b1;
    io.dig = 1'b0;

    // Reset, walking and turning
    step("reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_wl", outs(), 4'b1000);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_wl", outs(), 4'b1000);
    step("bump_l", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("turn_right", outs(), 4'b0100);
    step("bump_both", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("turn_left", outs(), 4'b1000);
    step("bump_r_ign", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("wl_ignores_br", outs(), 4'b1000);

    // Fall beats dig and bump; short fall survives
    step("fall_pri", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("fall_pri_aaah", outs(), 4'b0010);
    for (int i = 0; i < 4; i++) step("fall5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("land5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("land5_wl", outs(), 4'b1000);

    // Exactly 20 aaah cycles survives, in both directions
    do_fall("fall20l", 20);
    check("fall20_wl", outs(), 4'b1000);
    step("to_r", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_fall("fall20r", 20);
    check("fall20_wr", outs(), 4'b0100);

    // 21+ aaah cycles splats; SPLAT absorbs everything until reset
    foreach (splat_lens[k]) begin
      step("pre_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("pre_walk", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      do_fall("fall_long", splat_lens[k]);
      check("splat_out", outs(), 4'b0000);
      for (int i = 0; i < 20; i++) rnd_step("splat_rnd");
      check("splat_hold", outs(), 4'b0000);
    end
    step("rst_splat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_splat_wl", outs(), 4'b1000);

    // Dig while walking right, bumps ignored, fall out of the dig
    step("go_r", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("dig_r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("dig_r_on", outs(), 4'b0001);
    step("dig_bumps", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("dig_bumps2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("dig_hold", outs(), 4'b0001);
    step("dig_fall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dig_fall_aaah", outs(), 4'b0010);
    step("dig_land", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("dig_land_wr", outs(), 4'b0100);

    // Reset mid-fall and mid-dig ignores ground
    for (int i = 0; i < 10; i++) step("mid_fall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_fall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_fall_wl", outs(), 4'b1000);
    step("dig_l", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("rst_dig", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_dig_wl", outs(), 4'b1000);
    // Counter must restart after a reset that interrupted a fall
    for (int i = 0; i < 15; i++) step("pre_fall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_fall2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fall("refall", 20);
    check("refall_wl", outs(), 4'b1000);

    // Random run with occasional resets
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(31) == 0);
      step("random", r, 1'($urandom_range(1)), 1'($urandom_range(1)),
           ($urandom_range(5) != 0), ($urandom_range(3) == 0));
      if (r) check("random_rst_wl", outs(), 4'b1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
